// File: rtl/stopwatch_lap.sv
// Run/stop stopwatch with hour:min:sec:sub-second count and a circular lap buffer
// that can be stepped back through from the newest lap towards the oldest.
module stopwatch_lap #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned HOUR_MAX  = 24,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_runstop,
    input  logic                         i_clear,
    input  logic                         i_lap,
    input  logic                         i_recall,
    output logic [23:0]                  o_time,
    output logic [23:0]                  o_lap_time,
    output logic [$clog2(LAP_DEPTH):0]   o_lap_count,
    output logic [$clog2(LAP_DEPTH)-1:0] o_lap_idx,
    output logic                         o_lap_full,
    output logic                         o_running
);

    localparam int unsigned Div = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (Div > 2) ? $clog2(Div) : 1;
    localparam int unsigned IW  = $clog2(LAP_DEPTH);
    localparam int unsigned CW  = IW + 1;

    localparam logic [PW-1:0] PrescLast = PW'(Div - 1);
    localparam logic [6:0]    MsecLast  = 7'(TICK_HZ - 1);
    localparam logic [4:0]    HourLast  = 5'(HOUR_MAX - 1);
    localparam logic [CW-1:0] LapMax    = CW'(LAP_DEPTH);

    typedef enum logic {StStop, StRun} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    msec_q, msec_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [IW-1:0] wr_ptr_q, lap_idx_q, rd_ptr;
    logic [CW-1:0] lap_count_q;
    logic [23:0]   lap_mem [LAP_DEPTH];

    logic running, tick, do_clear, do_lap, do_recall;

    always_comb begin
        running   = (state_q == StRun);
        tick      = running && (presc_q == PrescLast);
        do_clear  = i_clear && !running;
        // Lap and clear both look at the state before any run/stop toggle.
        do_lap    = i_lap && running;
        do_recall = i_recall && (lap_count_q != '0) && !do_lap && !do_clear;
    end

    always_comb begin
        state_d = state_q;
        if (i_runstop) begin
            state_d = running ? StStop : StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StStop;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (do_clear) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (do_clear) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (tick) begin
            if (msec_q != MsecLast) begin
                msec_d = msec_q + 7'd1;
            end else begin
                msec_d = '0;
                if (sec_q != 6'd59) begin
                    sec_d = sec_q + 6'd1;
                end else begin
                    sec_d = '0;
                    if (min_q != 6'd59) begin
                        min_d = min_q + 6'd1;
                    end else begin
                        min_d  = '0;
                        hour_d = (hour_q == HourLast) ? '0 : hour_q + 5'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            msec_q      <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            wr_ptr_q    <= '0;
            lap_count_q <= '0;
            lap_idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            if (do_clear) begin
                wr_ptr_q    <= '0;
                lap_count_q <= '0;
                lap_idx_q   <= '0;
            end else if (do_lap) begin
                wr_ptr_q  <= wr_ptr_q + IW'(1);
                lap_idx_q <= '0;
                if (lap_count_q != LapMax) begin
                    lap_count_q <= lap_count_q + CW'(1);
                end
            end else if (do_recall) begin
                if (CW'(lap_idx_q) + CW'(1) == lap_count_q) begin
                    lap_idx_q <= '0;
                end else begin
                    lap_idx_q <= lap_idx_q + IW'(1);
                end
            end
        end
    end

    // Storage is never reset: an entry is only readable once lap_count covers it.
    always_ff @(posedge clk) begin
        if (!rst && do_lap) begin
            lap_mem[wr_ptr_q] <= o_time;
        end
    end

    assign rd_ptr      = wr_ptr_q - IW'(1) - lap_idx_q;
    assign o_time      = {hour_q, min_q, sec_q, msec_q};
    assign o_lap_time  = (lap_count_q == '0) ? 24'd0 : lap_mem[rd_ptr];
    assign o_lap_count = lap_count_q;
    assign o_lap_idx   = lap_idx_q;
    assign o_lap_full  = (lap_count_q == LapMax);
    assign o_running   = running;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench: tick-count/queue reference model, vector table, corner
// sequences, random stimulus, plus a fast-tick instance for the hour wrap.
module tb_stopwatch_lap;

    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int HOUR_MAX  = 2;
    localparam int LAP_DEPTH = 4;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int PERIOD    = HOUR_MAX * 3600 * TICK_HZ;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_runstop, i_clear, i_lap, i_recall;
    logic [23:0] o_time, o_lap_time;
    logic [2:0]  o_lap_count;
    logic [1:0]  o_lap_idx;
    logic        o_lap_full, o_running;

    logic        w_rst, w_runstop, w_zero;
    logic [23:0] w_time, w_lap_time;
    logic [1:0]  w_lap_count;
    logic        w_lap_idx, w_lap_full, w_running;

    stopwatch_lap #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .HOUR_MAX (HOUR_MAX),
        .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_runstop  (i_runstop),
        .i_clear    (i_clear),
        .i_lap      (i_lap),
        .i_recall   (i_recall),
        .o_time     (o_time),
        .o_lap_time (o_lap_time),
        .o_lap_count(o_lap_count),
        .o_lap_idx  (o_lap_idx),
        .o_lap_full (o_lap_full),
        .o_running  (o_running)
    );

    // One tick every two clocks so a full two-hour wrap fits in a short run.
    stopwatch_lap #(
        .CLK_HZ   (2),
        .TICK_HZ  (1),
        .HOUR_MAX (2),
        .LAP_DEPTH(2)
    ) dut_wrap (
        .clk        (clk),
        .rst        (w_rst),
        .i_runstop  (w_runstop),
        .i_clear    (w_zero),
        .i_lap      (w_zero),
        .i_recall   (w_zero),
        .o_time     (w_time),
        .o_lap_time (w_lap_time),
        .o_lap_count(w_lap_count),
        .o_lap_idx  (w_lap_idx),
        .o_lap_full (w_lap_full),
        .o_running  (w_running)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: elapsed time as a plain tick count, laps as a queue (newest first).
    bit m_run;
    int m_presc, m_ticks, m_idx;
    int m_laps[$];

    function automatic logic [23:0] pack(input int t);
        int ms, s, m, h;
        ms = t % TICK_HZ;
        s  = (t / TICK_HZ) % 60;
        m  = (t / (TICK_HZ * 60)) % 60;
        h  = t / (TICK_HZ * 3600);
        return {h[4:0], m[5:0], s[5:0], ms[6:0]};
    endfunction

    task automatic model_step(input logic r, rs, clr, lp, rc);
        bit was;
        int cur;
        if (r) begin
            m_run = 0; m_presc = 0; m_ticks = 0; m_idx = 0;
            m_laps.delete();
        end else begin
            was = m_run;
            cur = m_ticks;
            if (clr && !was) begin
                m_ticks = 0; m_presc = 0; m_idx = 0;
                m_laps.delete();
            end else begin
                if (was) begin
                    if (m_presc == DIV - 1) begin
                        m_presc = 0;
                        m_ticks = (m_ticks + 1) % PERIOD;
                    end else begin
                        m_presc++;
                    end
                end
                if (lp && was) begin
                    m_laps.push_front(cur);
                    if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_back());
                    m_idx = 0;
                end else if (rc && m_laps.size() > 0) begin
                    m_idx = (m_idx + 1) % m_laps.size();
                end
            end
            if (rs) m_run = !was;
        end
    endtask

    task automatic cycle(input logic r, rs, clr, lp, rc);
        logic [23:0] exp_lap;
        rst = r; i_runstop = rs; i_clear = clr; i_lap = lp; i_recall = rc;
        @(posedge clk);
        model_step(r, rs, clr, lp, rc);
        @(negedge clk);
        rst = 0; i_runstop = 0; i_clear = 0; i_lap = 0; i_recall = 0;
        exp_lap = (m_laps.size() > 0) ? pack(m_laps[m_idx]) : 24'd0;
        check("time", 32'(o_time), 32'(pack(m_ticks)));
        check("lap_time", 32'(o_lap_time), 32'(exp_lap));
        check("lap_count", 32'(o_lap_count), 32'(m_laps.size()));
        check("lap_idx", 32'(o_lap_idx), 32'(m_idx));
        check("lap_full", 32'(o_lap_full), 32'(m_laps.size() == LAP_DEPTH));
        check("running", 32'(o_running), 32'(m_run));
    endtask

    typedef struct {
        logic rs, clr, lp, rc;
        int   e_count, e_idx;
        logic e_run;
    } vec_t;

    vec_t        tbl[14];
    logic [23:0] exp_t;

    initial begin
        rst = 1; i_runstop = 0; i_clear = 0; i_lap = 0; i_recall = 0;
        w_rst = 1; w_runstop = 0; w_zero = 0;

        // Hour wrap on the fast instance.
        @(negedge clk);
        @(negedge clk);
        w_rst = 0; w_runstop = 1;
        @(negedge clk);
        w_runstop = 0;
        repeat (2 * 7199) @(negedge clk);
        exp_t = {5'd1, 6'd59, 6'd59, 7'd0};
        check("wrap_last", 32'(w_time), 32'(exp_t));
        repeat (2) @(negedge clk);
        check("wrap_zero", 32'(w_time), 32'd0);
        check("wrap_running", 32'(w_running), 32'd1);
        repeat (2) @(negedge clk);
        exp_t = {5'd0, 6'd0, 6'd1, 7'd0};
        check("wrap_continue", 32'(w_time), 32'(exp_t));

        // Reset state, then one second of counting and a freeze.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("rst_time", 32'(o_time), 32'd0);
        check("rst_running", 32'(o_running), 32'd0);
        check("rst_count", 32'(o_lap_count), 32'd0);
        cycle(0, 1, 0, 0, 0);
        repeat (1000) cycle(0, 0, 0, 0, 0);
        exp_t = {5'd0, 6'd0, 6'd1, 7'd0};
        check("one_second", 32'(o_time), 32'(exp_t));
        cycle(0, 1, 0, 0, 0);
        repeat (30) cycle(0, 0, 0, 0, 0);
        check("frozen_time", 32'(o_time), 32'(exp_t));
        check("frozen_running", 32'(o_running), 32'd0);

        // Vector table from a fresh reset.
        tbl[0]  = '{0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 1, 0, 1, 0, 1};
        tbl[4]  = '{1, 0, 1, 0, 2, 0, 0};
        tbl[5]  = '{0, 1, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 1, 0, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 1, 1, 0, 1};
        tbl[10] = '{0, 0, 1, 1, 2, 0, 1};
        tbl[11] = '{0, 0, 0, 1, 2, 1, 1};
        tbl[12] = '{1, 0, 0, 0, 2, 1, 0};
        tbl[13] = '{0, 0, 1, 0, 2, 1, 0};
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            cycle(0, tbl[i].rs, tbl[i].clr, tbl[i].lp, tbl[i].rc);
            check($sformatf("tbl%0d_count", i), 32'(o_lap_count), 32'(tbl[i].e_count));
            check($sformatf("tbl%0d_idx", i), 32'(o_lap_idx), 32'(tbl[i].e_idx));
            check($sformatf("tbl%0d_running", i), 32'(o_running), 32'(tbl[i].e_run));
        end

        // Five laps into four entries, then recall wraps through them.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int tgt = 10; tgt <= 50; tgt += 10) begin
            for (int k = 0; k < 2000 && m_ticks != tgt; k++) cycle(0, 0, 0, 0, 0);
            check($sformatf("reach_msec%0d", tgt), 32'(m_ticks), 32'(tgt));
            cycle(0, 0, 0, 1, 0);
        end
        check("laps_count", 32'(o_lap_count), 32'd4);
        check("laps_full", 32'(o_lap_full), 32'd1);
        exp_t = o_lap_time;
        check("lap_newest", 32'(exp_t[6:0]), 32'd50);
        for (int j = 0; j < 4; j++) begin
            cycle(0, 0, 0, 0, 1);
            exp_t = o_lap_time;
            check($sformatf("recall%0d", j), 32'(exp_t[6:0]), (j == 3) ? 32'd50 : 32'(40 - 10 * j));
        end

        // Clear ignored while running, honoured when stopped.
        cycle(0, 0, 1, 0, 0);
        check("clear_run_count", 32'(o_lap_count), 32'd4);
        check("clear_run_running", 32'(o_running), 32'd1);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        check("clear_time", 32'(o_time), 32'd0);
        check("clear_count", 32'(o_lap_count), 32'd0);
        check("clear_lap_time", 32'(o_lap_time), 32'd0);

        // Lap on the same edge as the 9->10 tick stores 9.
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 2000 && !(m_ticks == 9 && m_presc == DIV - 1); k++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        exp_t = o_lap_time;
        check("lap_tick_stored", 32'(exp_t[6:0]), 32'd9);
        exp_t = o_time;
        check("lap_tick_time", 32'(exp_t[6:0]), 32'd10);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        check("lap_stop_count", 32'(o_lap_count), 32'd1);
        check("lap_stop_running", 32'(o_running), 32'd1);

        // Reset mid-run with three laps stored.
        repeat (7) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (13) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        check("three_laps", 32'(o_lap_count), 32'd3);
        cycle(1, 0, 0, 0, 0);
        check("rst_mid_time", 32'(o_time), 32'd0);
        check("rst_mid_lap_time", 32'(o_lap_time), 32'd0);
        check("rst_mid_count", 32'(o_lap_count), 32'd0);
        check("rst_mid_idx", 32'(o_lap_idx), 32'd0);
        check("rst_mid_full", 32'(o_lap_full), 32'd0);
        check("rst_mid_running", 32'(o_running), 32'd0);
        cycle(0, 0, 0, 0, 1);
        check("rst_recall_lap_time", 32'(o_lap_time), 32'd0);

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(499) == 0), ($urandom_range(39) == 0),
                  ($urandom_range(29) == 0), ($urandom_range(9) == 0),
                  ($urandom_range(7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, the system clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 100, the count rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 The block SHALL have parameter HOUR_MAX, default 24, the hour modulus; legal range 2..32.
REQ-004 The block SHALL have parameter LAP_DEPTH, default 4, the lap buffer entries; legal range is a power of two, 2..16.
REQ-005 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-006 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port i_runstop, input, 1 bit, a one-cycle pulse that toggles run/stop.
REQ-008 The block SHALL have port i_clear, input, 1 bit, a one-cycle pulse that clears time and laps.
REQ-009 The block SHALL have port i_lap, input, 1 bit, a one-cycle pulse that captures a lap.
REQ-010 The block SHALL have port i_recall, input, 1 bit, a one-cycle pulse that steps to the next older lap.
REQ-011 The block SHALL have port o_time, output, 24 bits, the live time {hour[4:0], min[5:0], sec[5:0], msec[6:0]}.
REQ-012 The block SHALL have port o_lap_time, output, 24 bits, the recalled lap in the same packing.
REQ-013 The block SHALL have port o_lap_count, output, $clog2(LAP_DEPTH)+1 bits, the number of stored laps.
REQ-014 The block SHALL have port o_lap_idx, output, $clog2(LAP_DEPTH) bits, the recall position (0 = newest).
REQ-015 The block SHALL have port o_lap_full, output, 1 bit, asserted when o_lap_count == LAP_DEPTH.
REQ-016 The block SHALL have port o_running, output, 1 bit, asserted in state RUN.

Function
REQ-017 The block SHALL implement FSM states STOP and RUN: STOP->RUN and RUN->STOP each on i_runstop.
REQ-018 A tick prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 only in RUN, SHALL hold its value in STOP, and SHALL emit a one-cycle tick at the terminal count.
REQ-019 On each tick, msec SHALL count 0..TICK_HZ-1 with carry into sec (0..59), then min (0..59), then hour (0..HOUR_MAX-1).
REQ-020 At HOUR_MAX-1:59:59:TICK_HZ-1, the next tick SHALL wrap all fields to 0 and the count SHALL continue.
REQ-021 o_time SHALL be registered and SHALL update in the cycle after the tick.
REQ-022 i_clear in STOP SHALL zero the time, the prescaler, o_lap_count, the write pointer and o_lap_idx, and SHALL set o_lap_time to 0, effective the next cycle.
REQ-023 i_clear in RUN SHALL be ignored.
REQ-024 i_lap in RUN SHALL write the current registered o_time (the pre-tick value if a tick occurs in the same cycle) into the circular buffer at the write pointer.
REQ-025 On each lap write, the write pointer SHALL advance modulo LAP_DEPTH, o_lap_count SHALL saturate at LAP_DEPTH, and when full the oldest entry SHALL be overwritten.
REQ-026 Each lap write SHALL reset o_lap_idx to 0, and o_lap_time SHALL show the new lap in the next cycle.
REQ-027 i_lap in STOP SHALL be ignored.
REQ-028 When o_lap_count > 0, i_recall SHALL increment o_lap_idx modulo o_lap_count, and o_lap_time SHALL show the entry written o_lap_idx laps before the newest, one cycle later.
REQ-029 When o_lap_count == 0, i_recall SHALL be ignored and o_lap_time SHALL be 0.
REQ-030 i_recall SHALL be legal in either state.
REQ-031 If i_runstop and i_lap occur in the same cycle, the lap SHALL be evaluated against the state before the toggle: captured if the prior state was RUN, ignored if it was STOP.
REQ-032 If i_lap and i_recall occur in the same cycle, the lap SHALL take priority and o_lap_idx SHALL become 0.
REQ-033 If i_clear and i_runstop occur in the same cycle in STOP, the clear SHALL apply and the state SHALL become RUN from zero time.

Reset
REQ-034 rst SHALL be sampled on the rising clk edge, SHALL take priority over all inputs, and SHALL be able to abort any operation.
REQ-035 After rst, the state SHALL be STOP, and o_time, o_lap_time, o_lap_count, o_lap_idx, o_lap_full, o_running, the prescaler and the write pointer SHALL all be 0.
REQ-036 Lap buffer storage SHALL need no reset, because entries are unobservable until written.

Verification (CLK_HZ=1000, TICK_HZ=100, HOUR_MAX=2, LAP_DEPTH=4; 10 clocks per tick)
REQ-037 Scenario: rst, then i_runstop, then 1000 clocks -> o_time sec=1, msec=0; i_runstop again -> o_time frozen and o_running=0.
REQ-038 Scenario: run from 1:59:59:99 for one tick -> o_time wraps to 0 and counting continues.
REQ-039 Scenario: in RUN, five i_lap pulses at msec 10, 20, 30, 40 and 50 -> o_lap_count=4, o_lap_full=1, o_lap_time msec=50; three i_recall pulses -> msec 40, 30, 20; a fourth -> msec 50.
REQ-040 Scenario: i_clear while running -> no effect; stop then i_clear -> o_time=0, o_lap_count=0, o_lap_time=0.
REQ-041 Scenario: i_lap coincident with a tick at msec 9->10 -> stored msec=9; i_lap coincident with i_runstop in STOP -> o_lap_count unchanged and o_running=1.
REQ-042 Scenario: rst asserted mid-run with 3 laps stored -> all outputs 0 on the next cycle, and a following i_recall leaves o_lap_time=0.
